// File: rtl/mac_pkg.sv
// Shared definitions for the requantizing MAC output stage: FSM encoding and
// the clamp limits of the 8-bit activation range.
package mac_pkg;

  typedef enum logic [1:0] {
    S_HI   = 2'd0,
    S_LO   = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam int ACT_MAX_U = 127;
  localparam int ACT_MAX_S = 127;
  localparam int ACT_MIN_S = -128;

endpackage

// File: rtl/mac_requant_core.sv
// Combinational requantizer: rounding arithmetic right shift of a signed
// accumulator, then ReLU or signed clamp into an OUT_W-bit activation.
module requant_core
  import mac_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu,
  output logic [OUT_W-1:0]   act,
  output logic               sat
);

  localparam logic signed [ACC_W:0] L_ZERO  = '0;
  localparam logic signed [ACC_W:0] L_MAX_U = (ACC_W+1)'(ACT_MAX_U);
  localparam logic signed [ACC_W:0] L_MAX_S = (ACC_W+1)'(ACT_MAX_S);
  localparam logic signed [ACC_W:0] L_MIN_S = (ACC_W+1)'(ACT_MIN_S);

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_bias;
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_r;

  // One guard bit keeps acc + 2^(shift-1) from overflowing for any input.
  always_comb begin
    w_ext  = {acc[ACC_W-1], acc};
    w_bias = '0;
    if (shift != '0) begin
      w_bias = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
    end
    w_sum = w_ext + w_bias;
    w_r   = w_sum >>> shift;
  end

  always_comb begin
    act = w_r[OUT_W-1:0];
    sat = 1'b0;
    if (relu) begin
      // Zeroing negatives is the intended ReLU behaviour, not a clamp event.
      if (w_r < L_ZERO) begin
        act = '0;
      end else if (w_r > L_MAX_U) begin
        act = L_MAX_U[OUT_W-1:0];
        sat = 1'b1;
      end
    end else begin
      if (w_r > L_MAX_S) begin
        act = L_MAX_S[OUT_W-1:0];
        sat = 1'b1;
      end else if (w_r < L_MIN_S) begin
        act = L_MIN_S[OUT_W-1:0];
        sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_requant.sv
// Collects a 32-bit accumulator in two beats (upper first), requantizes it to
// one activation and counts clamp events for debug readout.
module mac_requant
  import mac_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int BEAT_W  = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_relu,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BEAT_W-1:0]  in_beat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_act,
  output logic               out_sat,
  output logic [CNT_W-1:0]   sat_count
);

  // Handshakes: a beat transfers on a rising edge where in_valid & in_ready;
  // a result transfers where out_valid & out_ready. out_valid is a register
  // and never looks at out_ready combinationally.

  state_t             r_state;
  logic [BEAT_W-1:0]  r_acc_hi;
  logic [BEAT_W-1:0]  r_acc_lo;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_relu;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_act;
  logic               r_out_sat;
  logic [CNT_W-1:0]   r_sat_count;

  logic [ACC_W-1:0]   w_acc;
  logic [OUT_W-1:0]   w_act;
  logic               w_sat;

  assign w_acc = {r_acc_hi, r_acc_lo};

  requant_core #(
    .ACC_W   (ACC_W),
    .SHIFT_W (SHIFT_W),
    .OUT_W   (OUT_W)
  ) u_core (
    .acc   (w_acc),
    .shift (r_shift),
    .relu  (r_relu),
    .act   (w_act),
    .sat   (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HI;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_act   <= '0;
      r_out_sat   <= 1'b0;
      r_sat_count <= '0;
    end else begin
      case (r_state)
        S_HI: begin
          // Config is only taken between results so a result never mixes settings.
          if (cfg_load) begin
            r_shift     <= cfg_shift;
            r_relu      <= cfg_relu;
            r_sat_count <= '0;
          end
          if (in_valid) begin
            r_acc_hi <= in_beat;
            r_state  <= S_LO;
          end
        end
        S_LO: begin
          if (in_valid) begin
            r_acc_lo <= in_beat;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_out_act   <= w_act;
          r_out_sat   <= w_sat;
          r_out_valid <= 1'b1;
          if (w_sat && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
          end
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_HI;
          end
        end
        default: r_state <= S_HI;
      endcase
    end
  end

  assign in_ready  = (r_state == S_HI) || (r_state == S_LO);
  assign out_valid = r_out_valid;
  assign out_act   = r_out_act;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
Downstream stage of the iterative MAC. It collects a 32-bit signed accumulator result in two 16-bit beats, upper half first. It then applies optional ReLU, a rounding arithmetic right shift and saturation, and emits one 8-bit activation whose [6:0] field is sized to feed the next MAC's 7-bit activation input. It also keeps a saturating count of clamped outputs for debug readout.

Parameters:
ACC_W, 32, accumulator width; must equal 2*BEAT_W
BEAT_W, 16, width of one input beat
OUT_W, 8, output activation width
SHIFT_W, 5, width of the requant shift amount
CNT_W, 8, width of the saturation event counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cfg_load  in  1  load cfg_shift/cfg_relu (honoured only in S_HI)
cfg_shift  in  SHIFT_W  right-shift amount, 0..31
cfg_relu  in  1  1 = ReLU/unsigned output, 0 = signed output
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_beat  in  BEAT_W  accumulator half: [31:16] first, then [15:0]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_act  out  OUT_W  requantized activation
out_sat  out  1  result was clamped (qualifies out_act)
sat_count  out  CNT_W  number of clamp events, saturates at all-ones

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over all other inputs:
  - State goes to S_HI; held accumulator half is discarded.
  - out_valid=0, out_act=0, out_sat=0, sat_count=0, in_ready=1.
  - Config: shift=0, relu=1.
- State S_HI: in_ready=1. On a handshake, latch in_beat as acc[31:16] and go to S_LO.
  - If cfg_load=1 in this state, latch shift/relu and clear sat_count.
  - cfg_load and a beat handshake in the same cycle are both honoured.
- State S_LO: in_ready=1. On a handshake, latch acc[15:0] and go to S_CALC. cfg_load is ignored.
- State S_CALC: in_ready=0. Requantize in one cycle, register out_act/out_sat, then go to S_OUT.
- State S_OUT: out_valid=1.
  - out_act and out_sat are held stable until out_ready=1.
  - On handshake: out_valid drops next cycle, state goes to S_HI.
  - cfg_load is ignored.
- Timing:
  - Latency: LO beat accepted at cycle N gives out_valid=1 at cycle N+2.
  - Best-case throughput is one result per 4 cycles.
  - out_valid never depends combinationally on out_ready.
- Arithmetic (signed, 33-bit intermediate, no overflow):
  - shift=0: r = acc.
  - shift>0: r = (acc + 2^(shift-1)) >>> shift, i.e. round half toward +inf.
- relu=1:
  - r<0 gives 0, with out_sat=0 (ReLU zeroing is not a clamp).
  - r>127 gives 127 (0x7F), with out_sat=1.
  - Otherwise out_act=r. Bit 7 is always 0.
- relu=0:
  - Clamp to [-128,127], two's complement.
  - out_sat=1 iff clamping occurred.
- sat_count increments in the S_CALC cycle when out_sat is set. It holds at 255.
- Reset mid-operation (S_LO, S_CALC or S_OUT): the pending result is dropped with no output.

Decomposition:
- Shared package mac_pkg holds:
  - State encoding S_HI=2'd0, S_LO=2'd1, S_CALC=2'd2, S_OUT=2'd3.
  - Constants ACT_MAX_U=127, ACT_MAX_S=127, ACT_MIN_S=-128.
- One combinational sub-module, requant_core (acc, shift, relu -> act, sat). It is instantiated once and registered in S_CALC.
- The FSM, beat capture, handshakes and counter stay in mac_requant.

Test Plan:
1. Rounding up: relu=1, shift=8, beats 0x0000 then 0x3280 (12928) -> out_act=0x33 (51), out_sat=0, out_valid 2 cycles after the LO beat, sat_count=0.
2. ReLU zeroing: relu=1, shift=4, acc=0xFFFFF000 -> out_act=0x00, out_sat=0, sat_count unchanged.
3. Signed clamp: relu=0, shift=4, acc=0xFFFFF000 -> r=-256 -> out_act=0x80, out_sat=1, sat_count=1.
4. Positive clamp: relu=1, shift=8, acc=0x00010000 -> out_act=0x7F, out_sat=1.
5. Backpressure and ignored config:
   - Hold out_ready=0 for 5 cycles -> out_act stable, in_ready=0 throughout.
   - cfg_load pulsed during S_OUT is ignored (the next result still uses the old shift).
6. Reset and counter limits:
   - rst after HI beat 0x1234 -> next beat is treated as HI; a full pair then yields the correct result.
   - 300 consecutive clamped results -> sat_count=255.
   - cfg_load in S_HI -> sat_count=0.
